// File: rtl/rv32i_single_cycle.sv
// rtl/rv32i_single_cycle.sv - single-cycle RV32I core with host-loadable instruction and data memories
module rv32i_single_cycle (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    input  logic        CFG_wea_in,
    input  logic [31:0] CFG_addr_in,
    input  logic [31:0] CFG_dina_in,
    input  logic        LDM_wea_in,
    input  logic [31:0] LDM_addra_in,
    input  logic [31:0] LDM_dina_in,
    output logic [31:0] LDM_douta_out,
    output logic        Met_jr_ra
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];
    logic [31:0] rf   [32];

    logic [31:0] pc, pc_next, instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] alu_b, alu_out;
    logic        alu_alt;
    logic        br_taken;
    logic [31:0] mem_addr, ld_word, ld_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_ok;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        core_en;
    logic        unused_addr_bits;

    assign instr  = imem[pc[11:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    assign core_en   = start_in && !rst_n;
    assign Met_jr_ra = (instr == 32'h0000_8067) && core_en;

    assign LDM_douta_out    = dmem[LDM_addra_in[11:2]];
    assign unused_addr_bits = ^{CFG_addr_in[31:12], CFG_addr_in[1:0],
                                LDM_addra_in[31:12], LDM_addra_in[1:0], mem_addr[31:12]};

    // instr[30] selects SUB/SRA for register ops; for immediates only SRAI uses it
    assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign alu_alt = (opcode == OPC_OP) ? instr[30] : (funct3 == 3'b101 && instr[30]);

    always_comb begin
        alu_out = 32'd0;
        case (funct3)
            3'b000: alu_out = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_out = rs1_val << alu_b[4:0];
            3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {31'd0, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = alu_alt ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                      : rs1_val >> alu_b[4:0];
            3'b110: alu_out = rs1_val | alu_b;
            3'b111: alu_out = rs1_val & alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000: br_taken = (rs1_val == rs2_val);
            3'b001: br_taken = (rs1_val != rs2_val);
            3'b100: br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: br_taken = !($signed(rs1_val) < $signed(rs2_val));
            3'b110: br_taken = (rs1_val < rs2_val);
            3'b111: br_taken = !(rs1_val < rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Sub-word accesses ignore address bits below their size, so nothing ever traps
    assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign ld_word  = dmem[mem_addr[11:2]];
    assign ld_half  = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_byte = ld_word[7:0];
        case (mem_addr[1:0])
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            2'd3:    ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
    end

    always_comb begin
        ld_ok  = 1'b1;
        ld_val = 32'd0;
        case (funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_val = ld_word;
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_ok  = 1'b0;
        endcase
    end

    always_comb begin
        pc_next  = pc + 32'd4;
        rd_we    = 1'b0;
        rd_wdata = 32'd0;
        st_mask  = 4'b0000;
        st_data  = 32'd0;
        case (opcode)
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OPC_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc + imm_u;
            end
            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc + 32'd4;
                pc_next  = pc + imm_j;
            end
            OPC_JALR: begin
                rd_we    = 1'b1;
                rd_wdata = pc + 32'd4;
                pc_next  = (rs1_val + imm_i) & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: begin
                if (br_taken) pc_next = pc + imm_b;
            end
            OPC_LOAD: begin
                rd_we    = ld_ok;
                rd_wdata = ld_val;
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000: begin
                        st_mask = 4'b0001 << mem_addr[1:0];
                        st_data = {4{rs2_val[7:0]}};
                    end
                    3'b001: begin
                        st_mask = mem_addr[1] ? 4'b1100 : 4'b0011;
                        st_data = {2{rs2_val[15:0]}};
                    end
                    3'b010: begin
                        st_mask = 4'b1111;
                        st_data = rs2_val;
                    end
                    default: st_mask = 4'b0000;
                endcase
            end
            OPC_OPIMM, OPC_OP: begin
                rd_we    = 1'b1;
                rd_wdata = alu_out;
            end
            default: rd_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (start_in) begin
            pc <= pc_next;
            if (rd_we && rd != 5'd0) rf[rd] <= rd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (CFG_wea_in) imem[CFG_addr_in[11:2]] <= CFG_dina_in;
    end

    // Host write is issued last so it overrides a same-word core store
    always_ff @(posedge clk) begin
        if (core_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_mask[b]) dmem[mem_addr[11:2]][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
        if (LDM_wea_in) dmem[LDM_addra_in[11:2]] <= LDM_dina_in;
    end
endmodule

// File: tb/tb_rv32i_single_cycle.sv
// tb/tb_rv32i_single_cycle.sv - directed self-checking bench for rv32i_single_cycle
module tb_rv32i_single_cycle;
    localparam logic [6:0] OP_IMM  = 7'h13;
    localparam logic [6:0] OP_LOAD = 7'h03;
    localparam logic [6:0] OP_JALR = 7'h67;

    logic        clk = 1'b0;
    logic        rst_n, start_in;
    logic        CFG_wea_in, LDM_wea_in;
    logic [31:0] CFG_addr_in, CFG_dina_in, LDM_addra_in, LDM_dina_in, LDM_douta_out;
    logic        Met_jr_ra;

    int checks = 0;
    int errors = 0;
    logic [31:0] prog[$];

    int          st_regs5[19] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 21, 31};
    logic [31:0] exp5[19] = '{32'hFFFFFFFE, 32'hFFFFFFF8, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h1FFFFFFF,
                              32'hFFFFFFD8, 32'hFFFFFFF8, 32'hABCDE000, 32'h00001034, 32'h1, 32'h4,
                              32'hABCDE123, 32'h000000F0, 32'h80000000, 32'hABCDE003, 32'h1,
                              32'h00000018, 32'h0};

    rv32i_single_cycle dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in),
        .CFG_wea_in(CFG_wea_in), .CFG_addr_in(CFG_addr_in), .CFG_dina_in(CFG_dina_in),
        .LDM_wea_in(LDM_wea_in), .LDM_addra_in(LDM_addra_in), .LDM_dina_in(LDM_dina_in),
        .LDM_douta_out(LDM_douta_out), .Met_jr_ra(Met_jr_ra)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dm(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        LDM_addra_in = addr;
        #1;
        check(tag, LDM_douta_out, exp);
    endtask

    task automatic dm_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        LDM_wea_in   = 1'b1;
        LDM_addra_in = addr;
        LDM_dina_in  = data;
        @(negedge clk);
        LDM_wea_in   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Loads prog into IM while reset is held, then releases reset with the core running
    task automatic load_prog();
        @(negedge clk);
        start_in = 1'b0;
        rst_n    = 1'b1;
        foreach (prog[i]) begin
            CFG_wea_in  = 1'b1;
            CFG_addr_in = i * 4;
            CFG_dina_in = prog[i];
            @(negedge clk);
        end
        CFG_wea_in = 1'b0;
        rst_n      = 1'b0;
        start_in   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; start_in = 1'b1;
        CFG_wea_in = 1'b0; CFG_addr_in = '0; CFG_dina_in = '0;
        LDM_wea_in = 1'b0; LDM_addra_in = '0; LDM_dina_in = '0;
        step(2);
        check("reset_pc", dut.pc, 32'h0);
        check("reset_met", {31'd0, Met_jr_ra}, 32'h0);
        start_in = 1'b0;

        // addi / sw / ret, then halt and met gating
        dm_write(32'h0, 32'hDEADBEEF);
        prog.delete();
        prog.push_back(32'h00100093);
        prog.push_back(32'h00102023);
        prog.push_back(32'h00008067);
        load_prog();
        step(2);
        check("p1_pc", dut.pc, 32'h8);
        check("p1_met", {31'd0, Met_jr_ra}, 32'h1);
        check_dm("p1_dm0", 32'h0, 32'h1);
        start_in = 1'b0;
        #1;
        check("met_halted", {31'd0, Met_jr_ra}, 32'h0);
        step(5);
        check("halt_pc", dut.pc, 32'h8);
        check_dm("halt_dm0", 32'h0, 32'h1);
        dm_write(32'h4, 32'h11223344);
        check_dm("halt_host_wr", 32'h4, 32'h11223344);
        start_in = 1'b1;
        rst_n    = 1'b1;
        #1;
        check("met_in_reset", {31'd0, Met_jr_ra}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("met_run", {31'd0, Met_jr_ra}, 32'h1);
        step(1);
        start_in = 1'b0;
        check("ret_target", dut.pc, 32'h0);
        check("met_after_ret", {31'd0, Met_jr_ra}, 32'h0);

        // lw / srai / srli
        dm_write(32'h10, 32'h80000000);
        dm_write(32'h14, 32'h0);
        dm_write(32'h18, 32'h0);
        prog.delete();
        prog.push_back(enc_i(12'h010, 0, 3'd2, 2, OP_LOAD));
        prog.push_back(enc_i(12'h404, 2, 3'd5, 3, OP_IMM));
        prog.push_back(enc_s(12'h014, 3, 0, 3'd2));
        prog.push_back(enc_i(12'h004, 2, 3'd5, 4, OP_IMM));
        prog.push_back(enc_s(12'h018, 4, 0, 3'd2));
        load_prog();
        step(5);
        start_in = 1'b0;
        check_dm("srai", 32'h14, 32'hF8000000);
        check_dm("srli", 32'h18, 32'h08000000);

        // byte / half loads and stores, misaligned addresses
        dm_write(32'h20, 32'h123456FF);
        dm_write(32'h24, 32'h8001F00F);
        dm_write(32'h44, 32'hAAAAAAAA);
        prog.delete();
        prog.push_back(enc_i(12'h020, 0, 3'd0, 5, OP_LOAD));
        prog.push_back(enc_s(12'h030, 5, 0, 3'd2));
        prog.push_back(enc_i(12'h020, 0, 3'd4, 6, OP_LOAD));
        prog.push_back(enc_s(12'h034, 6, 0, 3'd2));
        prog.push_back(enc_i(12'h05A, 0, 3'd0, 7, OP_IMM));
        prog.push_back(enc_s(12'h021, 7, 0, 3'd0));
        prog.push_back(enc_i(12'h024, 0, 3'd1, 8, OP_LOAD));
        prog.push_back(enc_s(12'h038, 8, 0, 3'd2));
        prog.push_back(enc_i(12'h026, 0, 3'd5, 9, OP_LOAD));
        prog.push_back(enc_s(12'h03C, 9, 0, 3'd2));
        prog.push_back(enc_i(12'h027, 0, 3'd2, 10, OP_LOAD));
        prog.push_back(enc_s(12'h040, 10, 0, 3'd2));
        prog.push_back(enc_s(12'h045, 7, 0, 3'd1));
        prog.push_back(enc_i(12'h021, 0, 3'd0, 11, OP_LOAD));
        prog.push_back(enc_s(12'h048, 11, 0, 3'd2));
        load_prog();
        step(15);
        start_in = 1'b0;
        check_dm("lb_neg", 32'h30, 32'hFFFFFFFF);
        check_dm("lbu", 32'h34, 32'h000000FF);
        check_dm("sb_lane1", 32'h20, 32'h12345AFF);
        check_dm("lh_neg", 32'h38, 32'hFFFFF00F);
        check_dm("lhu_hi", 32'h3C, 32'h00008001);
        check_dm("lw_misaligned", 32'h40, 32'h8001F00F);
        check_dm("sh_misaligned", 32'h44, 32'hAAAA005A);
        check_dm("lb_pos", 32'h48, 32'h0000005A);

        // branches, jal, jalr
        prog.delete();
        prog.push_back(enc_i(12'd7, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_b(13'd8, 0, 0, 3'd0));
        prog.push_back(enc_i(12'd99, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_s(12'h050, 1, 0, 3'd2));
        prog.push_back(enc_j(21'd12, 1));
        prog.push_back(enc_i(12'd99, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_i(12'd99, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_s(12'h054, 1, 0, 3'd2));
        prog.push_back(enc_i(12'hFFF, 0, 3'd0, 3, OP_IMM));
        prog.push_back(enc_b(13'd8, 0, 3, 3'd6));
        prog.push_back(enc_b(13'd8, 0, 3, 3'd4));
        prog.push_back(enc_i(12'd99, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_b(13'd8, 0, 3, 3'd1));
        prog.push_back(enc_i(12'd99, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_b(13'd8, 3, 0, 3'd5));
        prog.push_back(enc_i(12'd99, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_b(13'd8, 3, 0, 3'd7));
        prog.push_back(enc_i(12'd1, 1, 3'd0, 1, OP_IMM));
        prog.push_back(enc_i(12'h055, 0, 3'd0, 5, OP_JALR));
        prog.push_back(enc_i(12'd99, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_i(12'd99, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_s(12'h058, 1, 0, 3'd2));
        prog.push_back(enc_s(12'h05C, 5, 0, 3'd2));
        load_prog();
        step(4);
        check("jal_target", dut.pc, 32'h1C);
        step(11);
        start_in = 1'b0;
        check("branch_end_pc", dut.pc, 32'h5C);
        check_dm("beq_skip", 32'h50, 32'h7);
        check_dm("jal_link", 32'h54, 32'h14);
        check_dm("branch_path", 32'h58, 32'h15);
        check_dm("jalr_link", 32'h5C, 32'h4C);

        // x0 hard-wired, ALU ops, NOP-class instructions
        dm_write(32'h0, 32'hCAFEF00D);
        prog.delete();
        prog.push_back(enc_i(12'd5, 0, 3'd0, 0, OP_IMM));
        prog.push_back(enc_s(12'h000, 0, 0, 3'd2));
        prog.push_back(enc_i(12'hFFB, 0, 3'd0, 1, OP_IMM));
        prog.push_back(enc_i(12'd3, 0, 3'd0, 2, OP_IMM));
        prog.push_back(enc_r(7'h00, 2, 1, 3'd0, 3));
        prog.push_back(enc_r(7'h20, 2, 1, 3'd0, 4));
        prog.push_back(enc_r(7'h00, 2, 1, 3'd2, 5));
        prog.push_back(enc_r(7'h00, 2, 1, 3'd3, 6));
        prog.push_back(enc_r(7'h20, 2, 1, 3'd5, 7));
        prog.push_back(enc_r(7'h00, 2, 1, 3'd5, 8));
        prog.push_back(enc_r(7'h00, 2, 1, 3'd1, 9));
        prog.push_back(enc_r(7'h00, 2, 1, 3'd4, 10));
        prog.push_back(enc_u(20'hABCDE, 11, 7'h37));
        prog.push_back(enc_u(20'h00001, 12, 7'h17));
        prog.push_back(enc_i(12'hFFF, 2, 3'd3, 13, OP_IMM));
        prog.push_back(enc_i(12'hFFF, 1, 3'd4, 14, OP_IMM));
        prog.push_back(enc_i(12'h123, 11, 3'd6, 15, OP_IMM));
        prog.push_back(enc_i(12'h0F0, 1, 3'd7, 16, OP_IMM));
        prog.push_back(enc_i(12'h01F, 2, 3'd1, 17, OP_IMM));
        prog.push_back(enc_r(7'h00, 11, 2, 3'd6, 18));
        prog.push_back(enc_i(12'hFFC, 1, 3'd2, 19, OP_IMM));
        prog.push_back(enc_i(12'd35, 0, 3'd0, 20, OP_IMM));
        prog.push_back(enc_r(7'h00, 20, 2, 3'd1, 21));
        prog.push_back(32'h00000073);
        prog.push_back(32'h0000000F);
        prog.push_back(32'hFFFFFFFF);
        for (int k = 0; k < 19; k++)
            prog.push_back(enc_s(12'h100 + 12'(4 * k), 5'(st_regs5[k]), 0, 3'd2));
        load_prog();
        step(45);
        start_in = 1'b0;
        check_dm("x0_hardwired", 32'h0, 32'h0);
        for (int k = 0; k < 19; k++)
            check_dm($sformatf("alu_x%0d", st_regs5[k]), 32'h100 + 4 * k, exp5[k]);

        // reset asserted mid-run suppresses the pending store
        dm_write(32'h60, 32'h0000FFFF);
        prog.delete();
        prog.push_back(enc_i(12'd1, 1, 3'd0, 1, OP_IMM));
        prog.push_back(enc_s(12'h060, 1, 0, 3'd2));
        prog.push_back(enc_j(21'h1FFFF8, 0));
        load_prog();
        step(7);
        check("midrun_pc", dut.pc, 32'h4);
        rst_n = 1'b1;
        step(1);
        check("midrun_reset_pc", dut.pc, 32'h0);
        check_dm("midrun_dm_kept", 32'h60, 32'h2);
        rst_n = 1'b0;
        step(2);
        start_in = 1'b0;
        check_dm("regs_cleared", 32'h60, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
